// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and encodings for the EX-stage RV64M multiply/divide unit.
//   muldiv_state_t : IDLE / BUSY / DONE controller states
//   OPC_*          : major opcodes carrying M-extension ops (OP, OP-32)
//   FUNC7_MULDIV   : func7 value selecting the M extension
//   F3_*           : func3 encodings of the eight M-extension operations
package muldiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } muldiv_state_t;

    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP32     = 7'b0111011;
    localparam logic [6:0] FUNC7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

endpackage

// File: rtl/muldiv_divider.sv
// muldiv_divider: iterative restoring divider on unsigned magnitudes, one
// quotient bit per step. Also serves as the shared iteration counter for the
// multiplier, so it is loaded on every accepted operation.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   load       : capture dividend/divisor and arm the counter
//   w          : 1 = 32-bit operation (DATA_WIDTH/2 steps), 0 = full width
//   step       : perform one iteration this cycle
//   dividend   : dividend magnitude (low half only when w)
//   divisor    : divisor magnitude
//   last       : the current step is the final one
//   quotient   : quotient after the current step (final when last)
//   remainder  : remainder after the current step (final when last)
module muldiv_divider #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  w,
    input  logic                  step,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic                  last,
    output logic [DATA_WIDTH-1:0] quotient,
    output logic [DATA_WIDTH-1:0] remainder
);
    localparam int DW = DATA_WIDTH;
    localparam int HW = DATA_WIDTH / 2;
    localparam int CW = $clog2(DATA_WIDTH);

    logic [CW-1:0] cnt;
    logic [DW-1:0] rem_q;
    logic [DW-1:0] quo_q;
    logic [DW-1:0] dvs_q;
    logic [DW:0]   shifted;
    logic [DW:0]   diff;
    logic          fits;

    // quo_q doubles as the dividend shift register: dividend bits leave at the
    // top while quotient bits enter at the bottom.
    always_comb begin
        shifted   = {rem_q, quo_q[DW-1]};
        diff      = shifted - {1'b0, dvs_q};
        fits      = ~diff[DW];
        remainder = fits ? diff[DW-1:0] : shifted[DW-1:0];
        quotient  = {quo_q[DW-2:0], fits};
    end

    assign last = (cnt == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
        end else if (load) begin
            cnt   <= w ? CW'(HW - 1) : CW'(DW - 1);
            rem_q <= '0;
            // 32-bit dividends are parked in the upper half so the first
            // step already sees their MSB.
            quo_q <= w ? {dividend[HW-1:0], {HW{1'b0}}} : dividend;
            dvs_q <= divisor;
        end else if (step) begin
            cnt   <= cnt - 1'b1;
            rem_q <= remainder;
            quo_q <= quotient;
        end
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: EX-stage RV64M multiply/divide unit. Accepts an M-extension
// op from ID/EX, iterates over multiple cycles while stalling the front end,
// and delivers a result with its destination register id.
// Optional feature macro: MULDIV_FAST_MUL_EN -- multiplies complete in one
// cycle through a single wide multiplier; divides are unaffected.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   start           : ID/EX holds a valid instruction (level)
//   flush           : kill any in-flight op, no done
//   alu_op_in       : opcode (OP or OP-32)
//   alu_func3_in    : operation select
//   alu_func7_in    : must select the M extension
//   op_a, op_b      : rs1 / rs2 values
//   dest_in         : rd
//   stall_out       : hold PC, IF/ID and ID/EX
//   busy            : controller not idle
//   done            : one-cycle pulse, result/dest_out valid
//   result          : result, held until the next done
//   dest_out        : rd of the completed op
module ex_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH      = 64,
    parameter int REG_ID_WIDTH    = 5,
    parameter int ALU_OP_WIDTH    = 7,
    parameter int ALU_FUNC3_WIDTH = 3,
    parameter int ALU_FUNC7_WIDTH = 7
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       flush,
    input  logic [ALU_OP_WIDTH-1:0]    alu_op_in,
    input  logic [ALU_FUNC3_WIDTH-1:0] alu_func3_in,
    input  logic [ALU_FUNC7_WIDTH-1:0] alu_func7_in,
    input  logic [DATA_WIDTH-1:0]      op_a,
    input  logic [DATA_WIDTH-1:0]      op_b,
    input  logic [REG_ID_WIDTH-1:0]    dest_in,
    output logic                       stall_out,
    output logic                       busy,
    output logic                       done,
    output logic [DATA_WIDTH-1:0]      result,
    output logic [REG_ID_WIDTH-1:0]    dest_out
);
    localparam int DW = DATA_WIDTH;
    localparam int HW = DATA_WIDTH / 2;

    // Word ops keep the low half and sign-extend it.
    function automatic logic [DW-1:0] fit(input logic [DW-1:0] x, input logic w);
        fit = w ? {{HW{x[HW-1]}}, x[HW-1:0]} : x;
    endfunction

    // MUL and MULW take the low product half; MULH* take the high half.
    function automatic logic [DW-1:0] mul_pick(input logic [2*DW-1:0] p,
                                               input logic [2:0] f3, input logic w);
        mul_pick = fit((f3 == F3_MUL || w) ? p[DW-1:0] : p[2*DW-1:DW], w);
    endfunction

    muldiv_state_t          state;
    logic [2:0]             f3;
    logic                   w_in, is_div_in, signed_a, signed_b, accept;
    logic [DW-1:0]          a_ext, b_ext, mag_a, mag_b, a_min, spec_raw, spec_res;
    logic                   sign_a, sign_b, div_zero, div_ovf, special;

    logic                   w_q, neg_q, sign_a_q;
    logic [2:0]             f3_q;
    logic [REG_ID_WIDTH-1:0] dest_q;
    logic [2*DW-1:0]        prod_q, mcand_q, prod_next, prod_signed;
    logic [DW-1:0]          mplier_q;
    logic [DW-1:0]          quotient, remainder, q_fix, r_fix, iter_res;
    logic                   div_last;

    // ---------------- decode at accept ----------------
    assign f3        = alu_func3_in[2:0];
    assign w_in      = (alu_op_in == OPC_OP32);
    assign is_div_in = f3[2];
    assign signed_a  = (f3 != F3_MULHU) && (f3 != F3_DIVU) && (f3 != F3_REMU);
    assign signed_b  = (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    assign accept    = (state == IDLE) && start && !flush && !reset
                       && (alu_func7_in == FUNC7_MULDIV)
                       && (alu_op_in == OPC_OP || alu_op_in == OPC_OP32);

    assign a_ext  = w_in ? {{HW{signed_a & op_a[HW-1]}}, op_a[HW-1:0]} : op_a;
    assign b_ext  = w_in ? {{HW{signed_b & op_b[HW-1]}}, op_b[HW-1:0]} : op_b;
    assign sign_a = signed_a & a_ext[DW-1];
    assign sign_b = signed_b & b_ext[DW-1];
    assign mag_a  = sign_a ? -a_ext : a_ext;
    assign mag_b  = sign_b ? -b_ext : b_ext;

    // Most negative value of the operating width, as seen after extension.
    assign a_min    = w_in ? {{(HW+1){1'b1}}, {(HW-1){1'b0}}} : {1'b1, {(DW-1){1'b0}}};
    assign div_zero = (b_ext == '0);
    assign div_ovf  = signed_b && (a_ext == a_min) && (b_ext == '1);
    assign special  = is_div_in && (div_zero || div_ovf);
    // f3[1] distinguishes REM* from DIV*.
    assign spec_raw = div_zero ? (f3[1] ? a_ext : '1) : (f3[1] ? '0 : a_ext);
    assign spec_res = fit(spec_raw, w_in);

`ifdef MULDIV_FAST_MUL_EN
    logic [2*DW-1:0] fast_prod, fast_signed;
    logic [DW-1:0]   fast_res;
    assign fast_prod   = {{DW{1'b0}}, mag_a} * {{DW{1'b0}}, mag_b};
    assign fast_signed = (sign_a ^ sign_b) ? -fast_prod : fast_prod;
    assign fast_res    = mul_pick(fast_signed, f3, w_in);
`endif

    // ---------------- iterative datapath ----------------
    // Last multiply step is folded in combinationally so the result can be
    // registered on the same edge that enters DONE.
    assign prod_next   = prod_q + (mplier_q[0] ? mcand_q : '0);
    assign prod_signed = neg_q ? -prod_next : prod_next;
    assign q_fix       = neg_q ? -quotient : quotient;
    assign r_fix       = sign_a_q ? -remainder : remainder;
    assign iter_res    = f3_q[2] ? fit(f3_q[1] ? r_fix : q_fix, w_q)
                                 : mul_pick(prod_signed, f3_q, w_q);

    muldiv_divider #(.DATA_WIDTH(DW)) u_div (
        .clk       (clk),
        .reset     (reset),
        .load      (accept),
        .w         (w_in),
        .step      (state == BUSY),
        .dividend  (mag_a),
        .divisor   (mag_b),
        .last      (div_last),
        .quotient  (quotient),
        .remainder (remainder)
    );

    assign stall_out = accept || (state == BUSY);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

    // ---------------- controller ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            result   <= '0;
            dest_out <= '0;
            dest_q   <= '0;
            w_q      <= 1'b0;
            f3_q     <= '0;
            neg_q    <= 1'b0;
            sign_a_q <= 1'b0;
            prod_q   <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else if (flush) begin
            // done already visible in a DONE cycle; everything else is dropped.
            state <= IDLE;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    w_q      <= w_in;
                    f3_q     <= f3;
                    neg_q    <= sign_a ^ sign_b;
                    sign_a_q <= sign_a;
                    dest_q   <= dest_in;
                    prod_q   <= '0;
                    mcand_q  <= {{DW{1'b0}}, mag_a};
                    mplier_q <= w_in ? {{HW{1'b0}}, mag_b[HW-1:0]} : mag_b;
                    if (special) begin
                        result   <= spec_res;
                        dest_out <= dest_in;
                        state    <= DONE;
                    end
`ifdef MULDIV_FAST_MUL_EN
                    else if (!is_div_in) begin
                        result   <= fast_res;
                        dest_out <= dest_in;
                        state    <= DONE;
                    end
`endif
                    else begin
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    prod_q   <= prod_next;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    if (div_last) begin
                        result   <= iter_res;
                        dest_out <= dest_q;
                        state    <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
module tb_ex_muldiv_unit;
    import muldiv_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
    localparam int ML  = 1;
    localparam int MWL = 1;
`else
    localparam int ML  = 65;
    localparam int MWL = 33;
`endif
    localparam int DL  = 65;
    localparam int DWL = 33;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [6:0]  alu_op_in = '0;
    logic [2:0]  alu_func3_in = '0;
    logic [6:0]  alu_func7_in = '0;
    logic [63:0] op_a = '0;
    logic [63:0] op_b = '0;
    logic [4:0]  dest_in = '0;
    logic        stall_out, busy, done;
    logic [63:0] result;
    logic [4:0]  dest_out;

    ex_muldiv_unit dut (
        .clk(clk), .reset(reset), .start(start), .flush(flush),
        .alu_op_in(alu_op_in), .alu_func3_in(alu_func3_in), .alu_func7_in(alu_func7_in),
        .op_a(op_a), .op_b(op_b), .dest_in(dest_in),
        .stall_out(stall_out), .busy(busy), .done(done),
        .result(result), .dest_out(dest_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [63:0] a;
        logic [63:0] b;
        logic [4:0]  dest;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    typedef struct {
        logic [63:0] res;
        logic [4:0]  dest;
        int          due;
    } exp_t;

    exp_t        sbq[$];
    int          errors = 0;
    int          checks = 0;
    logic [63:0] last_res = '0;
    logic [4:0]  last_dest = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && done) begin
            chk("done_has_expect", sbq.size() != 0, 1);
            if (sbq.size() != 0) begin
                exp_t e;
                e = sbq.pop_front();
                chk("result", result, e.res);
                chk("dest_out", dest_out, e.dest);
                chk("done_cycle", cyc, e.due);
                last_res  = e.res;
                last_dest = e.dest;
            end
        end
    end

    // Called just after a posedge: presents the op for the current cycle.
    task automatic drive(input vec_t v, input logic [6:0] f7);
        alu_op_in    = v.op;
        alu_func3_in = v.f3;
        alu_func7_in = f7;
        op_a         = v.a;
        op_b         = v.b;
        dest_in      = v.dest;
        start        = 1'b1;
    endtask

    task automatic push(input vec_t v, input int a_cyc);
        exp_t e;
        e.res  = v.exp;
        e.dest = v.dest;
        e.due  = a_cyc + v.lat;
        sbq.push_back(e);
    endtask

    // Issue, then wait for done; stall must be high from A through A+lat-1.
    task automatic run_vec(input vec_t v);
        int scnt;
        bit seen;
        drive(v, FUNC7_MULDIV);
        push(v, cyc);
        scnt = 0;
        seen = 0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk);
            if (stall_out) scnt++;
            if (done) seen = 1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        chk("done_seen", seen, 1);
        chk("stall_cycles", scnt, v.lat);
    endtask

    vec_t vecs[18];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int   a_cyc;

        vecs[0]  = '{OPC_OP,   F3_MUL,    64'd7, -64'sd3, 5'd1, 64'hFFFF_FFFF_FFFF_FFEB, ML};
        vecs[1]  = '{OPC_OP,   F3_MULHU,  '1, '1, 5'd2, 64'hFFFF_FFFF_FFFF_FFFE, ML};
        vecs[2]  = '{OPC_OP,   F3_MULHSU, '1, 64'd2, 5'd3, '1, ML};
        vecs[3]  = '{OPC_OP,   F3_DIVU,   64'd100, 64'd0, 5'd4, '1, 1};
        vecs[4]  = '{OPC_OP,   F3_REMU,   64'd100, 64'd0, 5'd5, 64'd100, 1};
        vecs[5]  = '{OPC_OP,   F3_DIV,    64'h8000_0000_0000_0000, '1, 5'd6, 64'h8000_0000_0000_0000, 1};
        vecs[6]  = '{OPC_OP,   F3_REM,    64'h8000_0000_0000_0000, '1, 5'd7, 64'd0, 1};
        vecs[7]  = '{OPC_OP32, F3_DIV,    -64'sd7, 64'd2, 5'd8, 64'hFFFF_FFFF_FFFF_FFFD, DWL};
        vecs[8]  = '{OPC_OP32, F3_REM,    -64'sd7, 64'd2, 5'd9, '1, DWL};
        vecs[9]  = '{OPC_OP,   F3_MULH,   64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 5'd10, 64'h3FFF_FFFF_FFFF_FFFF, ML};
        vecs[10] = '{OPC_OP,   F3_DIV,    -64'sd100, 64'd7, 5'd11, 64'hFFFF_FFFF_FFFF_FFF2, DL};
        vecs[11] = '{OPC_OP,   F3_REM,    -64'sd100, 64'd7, 5'd12, 64'hFFFF_FFFF_FFFF_FFFE, DL};
        vecs[12] = '{OPC_OP,   F3_DIVU,   '1, 64'd3, 5'd13, 64'h5555_5555_5555_5555, DL};
        vecs[13] = '{OPC_OP32, F3_MUL,    64'h0000_0000_7FFF_FFFF, 64'd2, 5'd14, 64'hFFFF_FFFF_FFFF_FFFE, MWL};
        vecs[14] = '{OPC_OP32, F3_DIVU,   64'hFFFF_FFFF_FFFF_FFF0, 64'h10, 5'd15, 64'h0000_0000_0FFF_FFFF, DWL};
        vecs[15] = '{OPC_OP32, F3_REMU,   64'h1234_5678_0000_000A, 64'd3, 5'd16, 64'd1, DWL};
        vecs[16] = '{OPC_OP32, F3_DIV,    64'h0000_0000_8000_0000, '1, 5'd17, 64'hFFFF_FFFF_8000_0000, 1};
        vecs[17] = '{OPC_OP,   F3_REM,    64'd100, -64'sd7, 5'd18, 64'd2, DL};

        // Reset state
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_stall", stall_out, 0);
        chk("rst_result", result, 0);
        chk("rst_dest", dest_out, 0);
        @(posedge clk); #1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Wrong func7 is not an M op: no accept.
        v = '{OPC_OP, F3_MUL, 64'd3, 64'd3, 5'd20, 64'd9, ML};
        drive(v, 7'b0000000);
        @(negedge clk);
        chk("bad_f7_stall", stall_out, 0);
        @(posedge clk); #1;
        start = 1'b0;
        chk("bad_f7_busy", busy, 0);

        // Flush at A+10 of a DIV, then an immediate DIVU.
        v = '{OPC_OP, F3_DIV, 64'd100, 64'd7, 5'd21, 64'd14, DL};
        drive(v, FUNC7_MULDIV);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_busy", busy, 0);
        chk("flush_result_held", result, last_res);
        chk("flush_dest_held", dest_out, last_dest);
        run_vec('{OPC_OP, F3_DIVU, 64'd9, 64'd4, 5'd22, 64'd2, DL});

        // start held through the DONE cycle: exactly one done.
        v = '{OPC_OP, F3_DIVU, 64'd100, 64'd0, 5'd23, '1, 1};
        drive(v, FUNC7_MULDIV);
        push(v, cyc);
        @(posedge clk); #1;
        @(negedge clk);
        chk("hold_done", done, 1);
        chk("hold_stall_in_done", stall_out, 0);
        @(posedge clk); #1;
        start = 1'b0;
        chk("hold_no_reaccept", busy, 0);
        repeat (5) @(posedge clk);
        #1;

        // Reset mid-operation at A+20.
`ifdef MULDIV_FAST_MUL_EN
        v = '{OPC_OP, F3_DIVU, 64'd1000, 64'd3, 5'd24, 64'd333, DL};
`else
        v = '{OPC_OP, F3_MUL, 64'd7, -64'sd3, 5'd24, 64'hFFFF_FFFF_FFFF_FFEB, ML};
`endif
        drive(v, FUNC7_MULDIV);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_stall", stall_out, 0);
        chk("mid_rst_result", result, 0);
        chk("mid_rst_dest", dest_out, 0);
        repeat (70) @(posedge clk);
        #1;

        chk("sb_drained", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
